cmpr_match_accum: RTL

- Sequential stage directly downstream of the equality-compare macrocell.
- Consumes the compare result and its enable, and counts matches over a fixed window of enabled samples.
- Presents each window's match count and an all-match flag on a valid/ready output handshake.
- Back-pressures upstream through i0_ready while a result is waiting to be accepted.

---
 rtl/cmpr_match_accum.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cmpr_match_accum.sv
// Match accumulator downstream of the equality comparator: counts matching samples over a
// fixed window of accepted samples and hands each window's count out on a valid/ready port.
module cmpr_match_accum #(
   parameter int unsigned width     = 4,
   parameter int unsigned window    = 16,
   parameter int unsigned cnt_width = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [width-1:0]     i0,
   input  logic                 i0_enable,
   output logic                 i0_ready,
   output logic [cnt_width-1:0] o0,
   output logic                 o1,
   output logic                 o0_valid,
   input  logic                 o0_ready
);

   if ((window < 1) || ((2 ** cnt_width) <= window)) begin : g_bad_params
      $error("cmpr_match_accum: window must be in 1..2**cnt_width-1");
   end

   // Only bit 0 of the compare result carries the match flag.
   if (width > 1) begin : g_unused_bits
      logic unused_i0_hi;
      assign unused_i0_hi = ^i0[width-1:1];
   end

   localparam logic [cnt_width-1:0] LastIdx   = cnt_width'(window - 1);
   localparam logic [cnt_width-1:0] WindowCnt = cnt_width'(window);

   typedef enum logic [0:0] {
      StAccum,
      StHold
   } state_e;

   state_e               state_q, state_d;
   logic [cnt_width-1:0] sample_cnt_q, sample_cnt_d;
   logic [cnt_width-1:0] match_cnt_q, match_cnt_d;
   logic [cnt_width-1:0] o0_q, o0_d;
   logic                 o1_q, o1_d;
   logic                 valid_q, valid_d;

   logic                 sample_acc;
   logic                 result_acc;
   logic [cnt_width-1:0] match_sum;

   always_comb begin
      i0_ready = 1'b1;
      unique case (state_q)
         StAccum: i0_ready = 1'b1;
         StHold:  i0_ready = o0_ready;
         default: i0_ready = 1'b1;
      endcase
   end

   assign sample_acc = i0_enable & i0_ready & ~clear;
   assign result_acc = valid_q & o0_ready;
   assign match_sum  = match_cnt_q + cnt_width'(i0[0]);

   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      match_cnt_d  = match_cnt_q;
      o0_d         = o0_q;
      o1_d         = o1_q;
      valid_d      = valid_q;

      if (clear) begin
         state_d      = StAccum;
         sample_cnt_d = '0;
         match_cnt_d  = '0;
         o1_d         = 1'b0;
         valid_d      = 1'b0;
      end else begin
         if (result_acc) begin
            valid_d = 1'b0;
            state_d = StAccum;
         end
         // In HOLD a sample is only accepted alongside the result handoff, so it always starts
         // the next window; with window==1 it also completes that window immediately.
         if (sample_acc) begin
            if (sample_cnt_q == LastIdx) begin
               o0_d         = match_sum;
               o1_d         = (match_sum == WindowCnt);
               valid_d      = 1'b1;
               sample_cnt_d = '0;
               match_cnt_d  = '0;
               state_d      = StHold;
            end else begin
               sample_cnt_d = sample_cnt_q + 1'b1;
               match_cnt_d  = match_sum;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StAccum;
         sample_cnt_q <= '0;
         match_cnt_q  <= '0;
         o0_q         <= '0;
         o1_q         <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         match_cnt_q  <= match_cnt_d;
         o0_q         <= o0_d;
         o1_q         <= o1_d;
         valid_q      <= valid_d;
      end
   end

   assign o0       = o0_q;
   assign o1       = o1_q;
   assign o0_valid = valid_q;

endmodule
